// File: rtl/ibex_pkg.sv
// Shared types for the RVFI trace buffer: capability write descriptor,
// trace record layout, filter-mode encoding and trigger FSM states.
package ibex_pkg;

  // Capability register write as seen on the retirement stream; only the
  // tag (valid) is recorded, the other fields exist to match the core.
  typedef struct packed {
    logic       valid;
    logic [5:0] perms;
    logic [3:0] otype;
  } reg_cap_t;

  // Capture filter selected by mode_i.
  typedef enum logic [1:0] {
    TRACE_ALL  = 2'd0,  // every retirement
    TRACE_TRAP = 2'd1,  // traps and interrupts only
    TRACE_MEM  = 2'd2,  // loads/stores only
    TRACE_CAP  = 2'd3   // tagged capability writes to a real register
  } trace_mode_e;

  // One trace buffer entry.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        cap_tag;
    logic [31:0] mem_addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic        trap;
    logic        intr;
  } trace_rec_t;

  // Trigger-and-freeze states.
  typedef enum logic [1:0] {
    TRIG_IDLE   = 2'd0,
    TRIG_POST   = 2'd1,
    TRIG_FROZEN = 2'd2
  } trig_state_e;

  // True when a record passes the selected capture filter.
  function automatic logic trace_filter_match(trace_mode_e mode, trace_rec_t rec);
    logic match;
    case (mode)
      TRACE_ALL:  match = 1'b1;
      TRACE_TRAP: match = rec.trap | rec.intr;
      TRACE_MEM:  match = |(rec.rmask | rec.wmask);
      TRACE_CAP:  match = rec.cap_tag & (rec.rd_addr != 5'd0);
      default:    match = 1'b0;
    endcase
    return match;
  endfunction

endpackage

// File: rtl/ibex_rvfi_trace_buf_if.sv
// RVFI retirement stream bundle feeding the trace buffer.
interface ibex_rvfi_trace_buf_if;
  import ibex_pkg::*;

  logic        rvfi_valid;
  logic        rvfi_trap;
  logic        rvfi_intr;
  logic [31:0] rvfi_pc_rdata;
  logic [31:0] rvfi_insn;
  logic [4:0]  rvfi_rd_addr;
  logic [31:0] rvfi_rd_wdata;
  logic [31:0] rvfi_mem_addr;
  logic [3:0]  rvfi_mem_rmask;
  logic [3:0]  rvfi_mem_wmask;
  reg_cap_t    rvfi_rd_wcap;

  // Core side drives the stream.
  modport master (
    output rvfi_valid, rvfi_trap, rvfi_intr, rvfi_pc_rdata, rvfi_insn,
           rvfi_rd_addr, rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_rmask,
           rvfi_mem_wmask, rvfi_rd_wcap
  );

  // Trace buffer side observes it.
  modport slave (
    input rvfi_valid, rvfi_trap, rvfi_intr, rvfi_pc_rdata, rvfi_insn,
          rvfi_rd_addr, rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_rmask,
          rvfi_mem_wmask, rvfi_rd_wcap
  );
endinterface

// File: rtl/ibex_trace_ram.sv
// Trace record storage: one synchronous write port, one asynchronous read
// port so the head record is visible the cycle after it is written.
module ibex_trace_ram #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 32
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [Width-1:0]         rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  // Write the addressed entry.
  // NOTE: non-blocking assignment for all clocked state; the array has no
  // reset because occupancy is tracked by the pointers and count outside.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ibex_rvfi_trace_buf.sv
// RVFI trace buffer: filters retirements into a circular record buffer,
// drains through a valid/ready port and can freeze after a trap trigger.
module ibex_rvfi_trace_buf
  import ibex_pkg::*;
#(
  parameter int unsigned Depth           = 16,
  parameter int unsigned PostTrig        = 4,
  parameter bit          OverwriteOldest = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       en_i,
  input  logic [1:0]                 mode_i,
  input  logic                       freeze_on_trap_i,
  input  logic                       clear_i,
  ibex_rvfi_trace_buf_if.slave       rvfi,
  output logic                       rec_valid_o,
  input  logic                       rec_ready_i,
  output trace_rec_t                 rec_o,
  output logic [$clog2(Depth+1)-1:0] count_o,
  output logic                       frozen_o,
  output logic [15:0]                drop_cnt_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = $clog2(Depth + 1);
  localparam int unsigned PW = $clog2(Depth) + 1;
  localparam logic [CW-1:0] FullCnt  = CW'(Depth);
  localparam logic [PW-1:0] PostLast = PW'(PostTrig);

  trace_rec_t     new_rec;
  logic           capture, pop, full, drop, wr_en, rd_adv;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [15:0]    drop_cnt_q, drop_cnt_d;
  trig_state_e    state_q;
  logic [PW-1:0]  post_cnt_q;
  logic           frozen_q;
  logic [$bits(trace_rec_t)-1:0] ram_rdata;
  logic           unused_cap;

  // Assemble the candidate record from the retirement stream.
  // NOTE: default every always_comb output first so no latch is inferred.
  always_comb begin
    new_rec          = '0;
    new_rec.pc       = rvfi.rvfi_pc_rdata;
    new_rec.insn     = rvfi.rvfi_insn;
    new_rec.rd_addr  = rvfi.rvfi_rd_addr;
    new_rec.rd_wdata = rvfi.rvfi_rd_wdata;
    new_rec.cap_tag  = rvfi.rvfi_rd_wcap.valid;
    new_rec.mem_addr = rvfi.rvfi_mem_addr;
    new_rec.rmask    = rvfi.rvfi_mem_rmask;
    new_rec.wmask    = rvfi.rvfi_mem_wmask;
    new_rec.trap     = rvfi.rvfi_trap;
    new_rec.intr     = rvfi.rvfi_intr;
  end

  // Only the capability tag is traced.
  assign unused_cap = ^{rvfi.rvfi_rd_wcap.perms, rvfi.rvfi_rd_wcap.otype};

  assign capture = rvfi.rvfi_valid & en_i & ~frozen_q &
                   trace_filter_match(trace_mode_e'(mode_i), new_rec);
  assign pop     = rec_valid_o & rec_ready_i;
  assign full    = (count_q == FullCnt);
  // A full buffer without a same-cycle pop has no free slot.
  assign drop    = capture & full & ~pop;
  // Discard-newest suppresses the write; overwrite-oldest advances the head.
  assign wr_en   = capture & ~(drop & ~OverwriteOldest);
  assign rd_adv  = pop | (drop & OverwriteOldest);

  // Next-state for pointers, occupancy and drop counter; clear wins.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    if (clear_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      drop_cnt_d = '0;
    end else begin
      if (wr_en)  wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_adv) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_en && !rd_adv) begin
        count_d = count_q + 1'b1;
      end else if (!wr_en && rd_adv) begin
        count_d = count_q - 1'b1;
      end
      if (drop && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  // Buffer bookkeeping registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Trigger FSM: trap arms POST, PostTrig more captures freeze the buffer.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q    <= TRIG_IDLE;
      post_cnt_q <= '0;
      frozen_q   <= 1'b0;
    end else begin
      case (state_q)
        TRIG_IDLE: begin
          if (capture && new_rec.trap && freeze_on_trap_i) begin
            post_cnt_q <= '0;
            if (PostTrig == 0) begin
              state_q  <= TRIG_FROZEN;
              frozen_q <= 1'b1;
            end else begin
              state_q <= TRIG_POST;
            end
          end
        end
        TRIG_POST: begin
          // Traps seen here are plain records, never a new trigger.
          if (!freeze_on_trap_i) begin
            state_q <= TRIG_IDLE;
          end else if (capture) begin
            post_cnt_q <= post_cnt_q + 1'b1;
            if ((post_cnt_q + 1'b1) == PostLast) begin
              state_q  <= TRIG_FROZEN;
              frozen_q <= 1'b1;
            end
          end
        end
        TRIG_FROZEN: begin
          frozen_q <= 1'b1;
        end
        default: begin
          state_q  <= TRIG_IDLE;
          frozen_q <= 1'b0;
        end
      endcase
    end
  end

  ibex_trace_ram #(
    .Depth (Depth),
    .Width ($bits(trace_rec_t))
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_en & ~clear_i),
    .waddr_i (wr_ptr_q),
    .wdata_i (new_rec),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  assign rec_o       = trace_rec_t'(ram_rdata);
  assign rec_valid_o = (count_q != '0);
  assign count_o     = count_q;
  assign frozen_o    = frozen_q;
  assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: doc/ibex_rvfi_trace_buf.md
IBEX_RVFI_TRACE_BUF -- requirements
Module: ibex_rvfi_trace_buf

Interface
REQ-001 SHALL have parameter Depth, default 16, number of trace record entries; power of 2, 4..256.
REQ-002 SHALL have parameter PostTrig, default 4, records captured after a trigger before freezing; 0..Depth-1.
REQ-003 SHALL have parameter OverwriteOldest, default 1'b1; 1 = full buffer discards oldest, 0 = full buffer discards newest.
REQ-004 SHALL have port clk_i, input, 1, sole clock.
REQ-005 SHALL have port rst_i, input, 1, reset; one clock, synchronous active-high reset.
REQ-006 SHALL have port en_i, input, 1, capture enable.
REQ-007 SHALL have port mode_i, input, 2, filter: 0 all, 1 trap|intr only, 2 memory ops only, 3 capability register writes only.
REQ-008 SHALL have port freeze_on_trap_i, input, 1, arms trigger-and-freeze.
REQ-009 SHALL have port clear_i, input, 1, flush buffer, counters and frozen state.
REQ-010 SHALL have ports rvfi_valid, rvfi_trap, rvfi_intr, input, 1 each; rvfi_pc_rdata, rvfi_insn, rvfi_rd_wdata, rvfi_mem_addr, input, 32 each; rvfi_rd_addr, input, 5; rvfi_mem_rmask, rvfi_mem_wmask, input, 4 each; rvfi_rd_wcap, input, reg_cap_t; retirement stream.
REQ-011 SHALL have port rec_valid_o, input-side handshake output, 1, head record valid.
REQ-012 SHALL have port rec_ready_i, input, 1, consumer accepts head record.
REQ-013 SHALL have port rec_o, output, trace_rec_t, head record.
REQ-014 SHALL have ports count_o, output, $clog2(Depth+1), occupancy; frozen_o, output, 1; drop_cnt_o, output, 16, discarded-record count.

Function
REQ-015 SHALL form a record {pc, insn, rd_addr, rd_wdata, cap_tag=rvfi_rd_wcap.valid, mem_addr, rmask, wmask, trap, intr} from the retirement stream.
REQ-016 SHALL capture when rvfi_valid & en_i & ~frozen_o & filter-match; filter 2 matches (rmask|wmask)!=0; filter 3 matches cap_tag & rd_addr!=0.
REQ-017 SHALL present a captured record on rec_o with rec_valid_o=1 the cycle after capture into an empty buffer (1-cycle latency).
REQ-018 SHALL pop the head on rec_valid_o & rec_ready_i; rec_o SHALL remain stable while rec_valid_o=1 and rec_ready_i=0.
REQ-019 SHALL, when capture and pop coincide, perform both with no drop, including at full; count_o unchanged.
REQ-020 SHALL, on capture when full without pop, discard the oldest record if OverwriteOldest=1, else the new record; either case SHALL increment drop_cnt_o, saturating at 16'hFFFF.
REQ-021 SHALL use wrap-around pointers modulo Depth; count_o SHALL range 0..Depth.
REQ-022 SHALL run a trigger FSM: IDLE -> (captured record with trap=1 and freeze_on_trap_i=1) POST -> (PostTrig further records captured) FROZEN; PostTrig=0 goes IDLE -> FROZEN directly.
REQ-023 SHALL assert frozen_o only in FROZEN; draining SHALL remain possible while frozen.
REQ-024 SHALL ignore trap records arriving in POST as new triggers.
REQ-025 SHALL, on clear_i, empty the buffer, zero drop_cnt_o, return FSM to IDLE next cycle; clear_i SHALL override a same-cycle capture and pop.
REQ-026 SHALL treat deassertion of freeze_on_trap_i in POST as abort to IDLE.

Reset
REQ-027 SHALL, with rst_i high at a clk_i edge, set rec_valid_o=0, count_o=0, frozen_o=0, drop_cnt_o=0, FSM=IDLE, pointers=0; rec_o contents are don't-care.
REQ-028 SHALL discard all records and any in-progress trigger on reset mid-operation.

Structure
REQ-029 SHALL place trace_rec_t and the filter-mode encoding in ibex_pkg.
REQ-030 SHALL implement storage as sub-module ibex_trace_ram (Depth x $bits(trace_rec_t), one write port, one read port, no reset on storage).
REQ-031 SHALL not be instantiated for synthesis outside the RVFI-enabled tracing top.

Verification
REQ-032 Empty buffer, mode 0, one retire pc=0x8000_0000 -> rec_valid_o=1 next cycle, rec_o.pc=0x8000_0000, count_o=1.
REQ-033 Depth=16, OverwriteOldest=1, 20 retires, rec_ready_i=0 -> count_o=16, drop_cnt_o=4, first drained pc is retire #5.
REQ-034 OverwriteOldest=0, same stimulus -> count_o=16, drop_cnt_o=4, first drained pc is retire #1.
REQ-035 freeze_on_trap_i=1, PostTrig=4, trap on retire #3 of 10 -> frozen_o=1 after retire #7, count_o=7, retires #8-10 ignored, drop_cnt_o=0.
REQ-036 Full buffer, simultaneous retire and rec_ready_i=1 -> count_o stays 16, drop_cnt_o unchanged; mode 3 with rd_addr=0 cap write -> no capture.
REQ-037 clear_i asserted together with rvfi_valid while FROZEN -> next cycle count_o=0, frozen_o=0, drop_cnt_o=0, rec_valid_o=0.
